// File: rtl/tkr_event_merge_if.sv
// Bundle between the tracker event merger, the per-ASIC serial receivers
// and the downstream consumer of the merged 12-bit word stream.
//
// Output handshake: a word (OutData plus its OutChip/OutFirst/OutLast/OutPrty
// tags) transfers on a rising Clock edge where OutValid && OutReady. Once
// OutValid is high the word and its tags stay stable until that edge, and
// OutValid never drops without a transfer. OutReady may change freely.
interface tkr_event_merge_if #(
  parameter int NCHIPS = 12
);
  // Receiver side
  logic [NCHIPS-1:0]    NotEmpty;
  logic [12*NCHIPS-1:0] ChipData;
  logic [NCHIPS-1:0]    PrtyErrIn;
  logic [NCHIPS-1:0]    Send;
  logic [NCHIPS-1:0]    Strobe;
  // Merged output stream
  logic [11:0]          OutData;
  logic [3:0]           OutChip;
  logic                 OutValid;
  logic                 OutReady;
  logic                 OutFirst;
  logic                 OutLast;
  logic                 OutPrty;

  modport master (
    input  NotEmpty, ChipData, PrtyErrIn, OutReady,
    output Send, Strobe, OutData, OutChip, OutValid, OutFirst, OutLast, OutPrty
  );

  modport slave (
    output NotEmpty, ChipData, PrtyErrIn, OutReady,
    input  Send, Strobe, OutData, OutChip, OutValid, OutFirst, OutLast, OutPrty
  );
endinterface

// File: rtl/tkr_event_merge.sv
// Tracker event merger: once every receiver holds an event, drain one event
// from each receiver in chip order via Send/Strobe and present the words as
// one tagged 12-bit valid/ready stream. Counts events and parity-flagged
// chip headers.
module tkr_event_merge #(
  parameter int NCHIPS = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  tkr_event_merge_if.master bus,
  output logic              Busy,
  output logic [15:0]       EvtCnt,
  output logic [7:0]        PrtyCnt,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_REL   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CHIP = 4'(NCHIPS - 1);

  state_t      state_q, state_d;
  logic [3:0]  c_q, c_d;
  logic [3:0]  k_q, k_d;
  logic [4:0]  n_q, n_d;
  logic [11:0] data_q, data_d;
  logic [3:0]  chip_q, chip_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        prty_q, prty_d;
  logic [15:0] evt_q, evt_d;
  logic [7:0]  pcnt_q, pcnt_d;

  logic [11:0]       chip_word;
  logic              prty_bit;
  logic [4:0]        n_eff;
  logic              last_chip;
  logic [NCHIPS-1:0] send_pulse;
  logic [NCHIPS-1:0] strobe_pulse;

  // Select the current chip's receiver word and parity flag
  always_comb begin
    chip_word = '0;
    prty_bit  = 1'b0;
    for (int i = 0; i < NCHIPS; i++) begin
      if (c_q == 4'(i)) begin
        chip_word = bus.ChipData[12*i +: 12];
        prty_bit  = bus.PrtyErrIn[i];
      end
    end
  end

  // Decode the single Send/Strobe pulse for the current chip from the state
  always_comb begin
    send_pulse   = '0;
    strobe_pulse = '0;
    for (int i = 0; i < NCHIPS; i++) begin
      if (c_q == 4'(i)) begin
        send_pulse[i]   = (state_q == ST_ISSUE) && (k_q == 4'd0);
        strobe_pulse[i] = ((state_q == ST_ISSUE) && (k_q != 4'd0)) ||
                          (state_q == ST_REL);
      end
    end
  end

  // Next-state and datapath updates for the merge sequence
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    k_d     = k_q;
    n_d     = n_q;
    data_d  = data_q;
    chip_d  = chip_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    prty_d  = prty_q;
    evt_d   = evt_q;
    pcnt_d  = pcnt_q;
    // On the header word the word count comes straight from the data.
    n_eff     = (k_q == 4'd0) ? ({1'b0, chip_word[3:0]} + 5'd1) : n_q;
    last_chip = (c_q == LAST_CHIP);

    case (state_q)
      ST_IDLE: begin
        c_d = 4'd0;
        k_d = 4'd0;
        if (&bus.NotEmpty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        data_d  = chip_word;
        chip_d  = c_q;
        valid_d = 1'b1;
        if (k_q == 4'd0) begin
          n_d     = n_eff;
          first_d = 1'b1;
          prty_d  = prty_bit;
          if (prty_bit && (pcnt_q != 8'hFF)) pcnt_d = pcnt_q + 8'd1;
        end else begin
          first_d = 1'b0;
        end
        last_d  = ({1'b0, k_q} == (n_eff - 5'd1)) && last_chip;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (valid_q && bus.OutReady) begin
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          if ({1'b0, k_q} == (n_q - 5'd1)) begin
            state_d = ST_REL;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_REL: begin
        k_d = 4'd0;
        if (last_chip) begin
          evt_d   = evt_q + 16'd1;
          state_d = ST_IDLE;
        end else begin
          c_d     = c_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      c_q     <= 4'd0;
      k_q     <= 4'd0;
      n_q     <= 5'd1;
      data_q  <= 12'd0;
      chip_q  <= 4'd0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      prty_q  <= 1'b0;
      evt_q   <= 16'd0;
      pcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
      n_q     <= n_d;
      data_q  <= data_d;
      chip_q  <= chip_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      prty_q  <= prty_d;
      evt_q   <= evt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign bus.Send     = send_pulse;
  assign bus.Strobe   = strobe_pulse;
  assign bus.OutData  = data_q;
  assign bus.OutChip  = chip_q;
  assign bus.OutValid = valid_q;
  assign bus.OutFirst = first_q;
  assign bus.OutLast  = last_q;
  assign bus.OutPrty  = prty_q;
  assign Busy         = (state_q != ST_IDLE);
  assign EvtCnt       = evt_q;
  assign PrtyCnt      = pcnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tkr_event_merge.sv
// Bench for tkr_event_merge: receiver models driven by Send/Strobe, a table
// of event scenarios scored word by word, plus hand-written sequences for
// the empty-receiver wait, parity saturation and mid-event reset.
module tb_tkr_event_merge;

  localparam int NCH = 12;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  tkr_event_merge_if #(.NCHIPS(NCH)) bus ();
  logic        Busy;
  logic [15:0] EvtCnt;
  logic [7:0]  PrtyCnt;
  logic [2:0]  dbg_state;

  tkr_event_merge #(.NCHIPS(NCH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .Busy        (Busy),
    .EvtCnt      (EvtCnt),
    .PrtyCnt     (PrtyCnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- receiver models ----------------
  logic [11:0] mem [NCH][16];
  logic [11:0] cd  [NCH];
  int rd_idx     [NCH];
  int send_cnt   [NCH];
  int strobe_cnt [NCH];
  int rel_cnt    [NCH];

  always @(posedge Clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (bus.Send[c]) begin
        rd_idx[c]   <= 0;
        cd[c]       <= mem[c][0];
        send_cnt[c] <= send_cnt[c] + 1;
      end else if (bus.Strobe[c]) begin
        strobe_cnt[c] <= strobe_cnt[c] + 1;
        if (rd_idx[c] + 1 < int'(mem[c][0][3:0]) + 1) begin
          rd_idx[c] <= rd_idx[c] + 1;
          cd[c]     <= mem[c][rd_idx[c] + 1];
        end else begin
          rel_cnt[c] <= rel_cnt[c] + 1;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cd
    assign bus.ChipData[12*g +: 12] = cd[g];
  end

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];   // {prty, last, first, chip[3:0], data[11:0]}
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_evt;
  logic [7:0]  exp_prty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " OutValid"}, 32'(bus.OutValid), 0);
    chk({tag, " OutFirst"}, 32'(bus.OutFirst), 0);
    chk({tag, " OutLast"},  32'(bus.OutLast),  0);
    chk({tag, " OutPrty"},  32'(bus.OutPrty),  0);
    chk({tag, " OutData"},  32'(bus.OutData),  0);
    chk({tag, " OutChip"},  32'(bus.OutChip),  0);
    chk({tag, " SendStrobe"}, 32'({bus.Send, bus.Strobe}), 0);
    chk({tag, " Busy"},     32'(Busy),    0);
    chk({tag, " EvtCnt"},   32'(EvtCnt),  0);
    chk({tag, " PrtyCnt"},  32'(PrtyCnt), 0);
    chk({tag, " state"},    32'(dbg_state), 0);
  endtask

  // ---------------- driver tasks ----------------
  // Load one event into every receiver and queue the expected merged words.
  task automatic setup(input int big_chip, input int big_nclus, input int prty_chip);
    logic [NCH-1:0] one;
    int n;
    one = 1;
    exp_q.delete();
    bus.PrtyErrIn = (prty_chip >= 0) ? (one << prty_chip) : '0;
    for (int c = 0; c < NCH; c++) begin
      n = (c == big_chip) ? big_nclus + 1 : 1;
      mem[c][0] = {4'(c), 4'($urandom_range(0, 15)), 4'(n - 1)};
      for (int w = 1; w < 16; w++) mem[c][w] = 12'($urandom_range(0, 4095));
      for (int w = 0; w < n; w++)
        exp_q.push_back({(c == prty_chip), (w == n - 1 && c == NCH - 1), (w == 0),
                         4'(c), mem[c][w]});
    end
  endtask

  task automatic run_event(input string tag, input int big_chip, input int big_nclus,
                           input int prty_chip, input int stall_chip, input int stall_word,
                           input int stall_len, input int exp_words, input int exp_busy,
                           input int exp_prty_inc);
    int cyc = 0, busy_cyc = 0, words = 0, first_send = -1, wic = 0, cur = 0;
    int stall_left, sends0 = 0, rels0 = 0, strb0, sends1 = 0, rels1 = 0;
    bit started = 0, done = 0, onehot_bad = 0, stall_bad = 0, stable_bad = 0, ready;
    logic [18:0] got, snap, exp;
    snap = '0;
    setup(big_chip, big_nclus, prty_chip);
    for (int c = 0; c < NCH; c++) begin
      sends0 += send_cnt[c];
      rels0  += rel_cnt[c];
    end
    strb0      = strobe_cnt[big_chip];
    stall_left = stall_len;
    bus.NotEmpty = '1;
    while (!done && cyc < 2000) begin
      @(negedge Clock);
      cyc++;
      if (Busy) begin
        busy_cyc++;
        started = 1;
        bus.NotEmpty = '0;
      end else if (started) begin
        done = 1;
      end
      if (first_send < 0 && bus.Send[0]) first_send = cyc;
      if ($countones({bus.Send, bus.Strobe}) > 1) onehot_bad = 1;
      ready = 1;
      got = {bus.OutPrty, bus.OutLast, bus.OutFirst, bus.OutChip, bus.OutData};
      if (bus.OutValid) begin
        cur = bus.OutFirst ? 0 : wic;
        if (int'(bus.OutChip) == stall_chip && cur == stall_word && stall_left > 0) begin
          if (stall_left == stall_len) snap = got;
          else if (got !== snap) stable_bad = 1;
          if (|{bus.Send, bus.Strobe}) stall_bad = 1;
          stall_left--;
          ready = 0;
        end
      end
      bus.OutReady = ready;
      if (bus.OutValid && ready) begin
        words++;
        if (exp_q.size() == 0) begin
          chk({tag, " extra word"}, 32'(got), 32'h7FFFF);
        end else begin
          exp = exp_q.pop_front();
          chk({tag, " word"}, 32'(got), 32'(exp));
        end
        wic = bus.OutFirst ? 1 : wic + 1;
      end
    end
    bus.OutReady = 1;
    for (int c = 0; c < NCH; c++) begin
      sends1 += send_cnt[c];
      rels1  += rel_cnt[c];
    end
    exp_evt  = exp_evt + 16'd1;
    exp_prty = (int'(exp_prty) + exp_prty_inc > 255) ? 8'd255 : exp_prty + 8'(exp_prty_inc);
    chk({tag, " done"},       32'(done), 1);
    chk({tag, " words"},      32'(words), 32'(exp_words));
    chk({tag, " leftover"},   32'(exp_q.size()), 0);
    chk({tag, " busy_cyc"},   32'(busy_cyc), 32'(exp_busy));
    chk({tag, " first_send"}, 32'(first_send), 1);
    chk({tag, " sends"},      32'(sends1 - sends0), NCH);
    chk({tag, " releases"},   32'(rels1 - rels0), NCH);
    chk({tag, " big_strobes"}, 32'(strobe_cnt[big_chip] - strb0), 32'(big_nclus + 1));
    chk({tag, " onehot"},     32'(onehot_bad), 0);
    chk({tag, " stall_pulse"}, 32'(stall_bad), 0);
    chk({tag, " stall_stable"}, 32'(stable_bad), 0);
    chk({tag, " stall_used"}, 32'(stall_left), 0);
    chk({tag, " EvtCnt"},     32'(EvtCnt), 32'(exp_evt));
    chk({tag, " PrtyCnt"},    32'(PrtyCnt), 32'(exp_prty));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    int big_chip;  int big_nclus;  int prty_chip;
    int stall_chip; int stall_word; int stall_len;
    int exp_words; int exp_busy;  int exp_prty_inc;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    bit idle_bad, found;
    vecs[0] = '{"all_n1",     0,  0, -1, -1, 0,  0, 12, 48, 0};
    vecs[1] = '{"chip3_n16",  3, 15, -1, -1, 0,  0, 27, 93, 0};
    vecs[2] = '{"stall_c5w1", 5,  2, -1,  5, 1, 20, 14, 74, 0};
    vecs[3] = '{"prty7_c11",  11, 4,  7, -1, 0,  0, 16, 60, 1};
    vecs[4] = '{"stall_c0w0", 0,  7, -1,  0, 0,  5, 19, 74, 0};

    Reset         = 1'b1;
    bus.NotEmpty  = '0;
    bus.PrtyErrIn = '0;
    bus.OutReady  = 1'b1;
    exp_evt       = 16'd0;
    exp_prty      = 8'd0;
    repeat (3) @(negedge Clock);
    check_reset("reset");
    Reset = 1'b0;
    @(negedge Clock);

    // Chip 0 empty: nothing may start until every receiver has an event.
    bus.NotEmpty = {{(NCH - 1){1'b1}}, 1'b0};
    idle_bad = 0;
    repeat (100) begin
      @(negedge Clock);
      if (Busy || (|{bus.Send, bus.Strobe})) idle_bad = 1;
    end
    chk("wait_idle", 32'(idle_bad), 0);

    for (int i = 0; i < 5; i++)
      run_event(vecs[i].name, vecs[i].big_chip, vecs[i].big_nclus, vecs[i].prty_chip,
                vecs[i].stall_chip, vecs[i].stall_word, vecs[i].stall_len,
                vecs[i].exp_words, vecs[i].exp_busy, vecs[i].exp_prty_inc);

    // Parity counter saturation over 300 chip-7 parity events.
    for (int i = 0; i < 300; i++)
      run_event("prty_sat", 0, 0, 7, -1, 0, 0, 12, 48, 1);
    chk("prty_sat final", 32'(PrtyCnt), 255);

    // Reset while stalled in chip 4 HOLD.
    setup(0, 0, -1);
    bus.NotEmpty = '1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clock);
      if (Busy) bus.NotEmpty = '0;
      if (bus.OutValid && bus.OutChip == 4'd4) begin
        found = 1;
        bus.OutReady = 1'b0;
      end
    end
    chk("reach_chip4", 32'(found), 1);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_reset("mid_reset");
    Reset = 1'b0;
    exp_evt  = 16'd0;
    exp_prty = 8'd0;
    @(negedge Clock);
    run_event("after_reset", 6, 1, 2, -1, 0, 0, 13, 51, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
